init_ctrl: RTL and testbench

- Responder to the PMU INIT_ON phase: the PMU raises init_en, and this block reads the tag's configuration words from NVM through a req/ack read port.
- It latches the kill status, lock configuration and kill-password presence, then returns a one-cycle init_done pulse plus a stable tag_status.
- Sits between the PMU, which consumes init_done and tag_status, and the NVM/IE read arbiter.

---
 rtl/init_ctrl_if.sv | 24 ++
 rtl/init_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_init_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/init_ctrl_if.sv
// NVM word-read port between the init controller and the NVM/IE read arbiter.
// rd_req is a registered level; rd_data is valid in the cycle rd_ack is high.
interface init_ctrl_if #(
   parameter int ADDR_W = 6
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_ack;
   logic [15:0]       rd_data;

   modport master (
      output rd_req,
      output rd_addr,
      input  rd_ack,
      input  rd_data
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      output rd_ack,
      output rd_data
   );
endinterface

// File: rtl/init_ctrl.sv
// INIT_ON responder: reads config words 0..3 from NVM, latches kill/lock/password
// status, then pulses init_done with a stable tag_status for the PMU.
//
// state  | meaning
// IDLE   | waiting for init_en; leaving it clears results and shadows
// ARM    | one settle cycle after enable
// ADDR   | first word address presented, rd_req still low
// REQ    | rd_req high, waiting for rd_ack or timeout
// GAP    | rd_req low for one cycle between words
// EVAL   | results derived from shadow words into the staging registers
// DONE   | staged results committed together with the init_done pulse
// HOLD   | results held until the PMU drops init_en
module init_ctrl #(
   parameter int ADDR_W     = 6,
   parameter int START_ADDR = 0,
   parameter int TO_MAX     = 255
) (
   input  logic          pmu_clk,
   input  logic          rst_n,
   input  logic          init_en,
   init_ctrl_if.master   nvm,
   output logic          init_done,
   output logic          tag_status,
   output logic [15:0]   lock_cfg,
   output logic          kill_pwd_nz,
   output logic          init_err
);

   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
   localparam logic [7:0]        TO_LAST = 8'(TO_MAX - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_ADDR,
      S_REQ,
      S_GAP,
      S_EVAL,
      S_DONE,
      S_HOLD
   } state_e;

   state_e            state_q,    state_d;
   logic [1:0]        idx_q,      idx_d;
   logic [1:0]        idx_nxt;
   logic [7:0]        to_cnt_q,   to_cnt_d;
   logic              rd_req_q,   rd_req_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;

   logic              w0_kill_q,  w0_kill_d;
   logic [15:0]       w1_q,       w1_d;
   logic              pwd_nz_q,   pwd_nz_d;

   logic              stg_tag_q,  stg_tag_d;
   logic [15:0]       stg_lock_q, stg_lock_d;
   logic              stg_pwd_q,  stg_pwd_d;
   logic              stg_err_q,  stg_err_d;

   logic              done_q,     done_d;
   logic              tag_q,      tag_d;
   logic [15:0]       lock_q,     lock_d;
   logic              pwd_q,      pwd_d;
   logic              err_q,      err_d;

   assign idx_nxt = idx_q + 2'd1;

   always_ff @(posedge pmu_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= 2'd0;
         to_cnt_q   <= 8'd0;
         rd_req_q   <= 1'b0;
         rd_addr_q  <= '0;
         w0_kill_q  <= 1'b0;
         w1_q       <= 16'h0000;
         pwd_nz_q   <= 1'b0;
         stg_tag_q  <= 1'b0;
         stg_lock_q <= 16'h0000;
         stg_pwd_q  <= 1'b0;
         stg_err_q  <= 1'b0;
         done_q     <= 1'b0;
         tag_q      <= 1'b0;
         lock_q     <= 16'h0000;
         pwd_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         to_cnt_q   <= to_cnt_d;
         rd_req_q   <= rd_req_d;
         rd_addr_q  <= rd_addr_d;
         w0_kill_q  <= w0_kill_d;
         w1_q       <= w1_d;
         pwd_nz_q   <= pwd_nz_d;
         stg_tag_q  <= stg_tag_d;
         stg_lock_q <= stg_lock_d;
         stg_pwd_q  <= stg_pwd_d;
         stg_err_q  <= stg_err_d;
         done_q     <= done_d;
         tag_q      <= tag_d;
         lock_q     <= lock_d;
         pwd_q      <= pwd_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      to_cnt_d   = to_cnt_q;
      rd_req_d   = rd_req_q;
      rd_addr_d  = rd_addr_q;
      w0_kill_d  = w0_kill_q;
      w1_d       = w1_q;
      pwd_nz_d   = pwd_nz_q;
      stg_tag_d  = stg_tag_q;
      stg_lock_d = stg_lock_q;
      stg_pwd_d  = stg_pwd_q;
      stg_err_d  = stg_err_q;
      done_d     = 1'b0;
      tag_d      = tag_q;
      lock_d     = lock_q;
      pwd_d      = pwd_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (init_en) begin
               idx_d     = 2'd0;
               to_cnt_d  = 8'd0;
               w0_kill_d = 1'b0;
               w1_d      = 16'h0000;
               pwd_nz_d  = 1'b0;
               tag_d     = 1'b0;
               lock_d    = 16'h0000;
               pwd_d     = 1'b0;
               err_d     = 1'b0;
               state_d   = S_ARM;
            end
         end
         S_ARM: begin
            if (!init_en) begin
               state_d = S_IDLE;
            end else begin
               rd_addr_d = START_A;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (!init_en) begin
               state_d = S_IDLE;
            end else begin
               rd_req_d = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (!init_en) begin
               rd_req_d = 1'b0;
               to_cnt_d = 8'd0;
               state_d  = S_IDLE;
            end else if (nvm.rd_ack) begin
               // ack beats a timeout expiring in the same cycle
               case (idx_q)
                  2'd0:    w0_kill_d = nvm.rd_data[0];
                  2'd1:    w1_d      = nvm.rd_data;
                  default: pwd_nz_d  = pwd_nz_q | (|nvm.rd_data);
               endcase
               rd_req_d = 1'b0;
               to_cnt_d = 8'd0;
               state_d  = S_GAP;
            end else if (to_cnt_q == TO_LAST) begin
               // fail-silent: report the tag as killed so the PMU parks
               rd_req_d   = 1'b0;
               to_cnt_d   = 8'd0;
               stg_tag_d  = 1'b1;
               stg_lock_d = 16'hFFFF;
               stg_pwd_d  = 1'b0;
               stg_err_d  = 1'b1;
               state_d    = S_DONE;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         S_GAP: begin
            if (!init_en) begin
               state_d = S_IDLE;
            end else if (idx_q == 2'd3) begin
               state_d = S_EVAL;
            end else begin
               idx_d     = idx_nxt;
               rd_addr_d = START_A + ADDR_W'(idx_nxt);
               rd_req_d  = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_EVAL: begin
            if (!init_en) begin
               state_d = S_IDLE;
            end else begin
               stg_tag_d  = w0_kill_q;
               stg_lock_d = w1_q;
               stg_pwd_d  = pwd_nz_q;
               stg_err_d  = 1'b0;
               state_d    = S_DONE;
            end
         end
         S_DONE: begin
            // commit with the pulse so tag_status never rises ahead of init_done
            done_d  = 1'b1;
            tag_d   = stg_tag_q;
            lock_d  = stg_lock_q;
            pwd_d   = stg_pwd_q;
            err_d   = stg_err_q;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!init_en) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign nvm.rd_req  = rd_req_q;
   assign nvm.rd_addr = rd_addr_q;
   assign init_done   = done_q;
   assign tag_status  = tag_q;
   assign lock_cfg    = lock_q;
   assign kill_pwd_nz = pwd_q;
   assign init_err    = err_q;

endmodule

// File: tb/tb_init_ctrl.sv
// Directed bench for init_ctrl: NVM responder with per-word wait states and a
// no-ack word, edge-counted init_done latency, and result/abort/reset checks.
module tb_init_ctrl;

   localparam int ADDR_W = 6;
   localparam int START  = 0;

   logic        pmu_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        init_en = 1'b0;
   logic        init_done;
   logic        tag_status;
   logic [15:0] lock_cfg;
   logic        kill_pwd_nz;
   logic        init_err;

   init_ctrl_if #(.ADDR_W(ADDR_W)) nvm ();

   init_ctrl #(
      .ADDR_W     (ADDR_W),
      .START_ADDR (START),
      .TO_MAX     (255)
   ) dut (
      .pmu_clk     (pmu_clk),
      .rst_n       (rst_n),
      .init_en     (init_en),
      .nvm         (nvm),
      .init_done   (init_done),
      .tag_status  (tag_status),
      .lock_cfg    (lock_cfg),
      .kill_pwd_nz (kill_pwd_nz),
      .init_err    (init_err)
   );

   always #5 pmu_clk = ~pmu_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // NVM responder: acks after dly wait cycles; word no_ack_w never acks
   logic [15:0] mem [4];
   int dly      = 0;
   int no_ack_w = -1;
   int wcnt     = 0;

   always @(negedge pmu_clk) begin
      if (nvm.rd_req === 1'b1) begin
         if (int'(nvm.rd_addr) == no_ack_w) begin
            nvm.rd_ack = 1'b0;
         end else if (wcnt >= dly) begin
            nvm.rd_ack  = 1'b1;
            nvm.rd_data = mem[nvm.rd_addr[1:0]];
         end else begin
            nvm.rd_ack = 1'b0;
            wcnt++;
         end
      end else begin
         nvm.rd_ack  = 1'b0;
         nvm.rd_data = 16'h0000;
         wcnt        = 0;
      end
   end

   task automatic set_mem(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
      mem[0] = w0;
      mem[1] = w1;
      mem[2] = w2;
      mem[3] = w3;
   endtask

   // Runs one init from IDLE; holds init_en 2 cycles past init_done, then drops it.
   task automatic run_seq(input string tag, input int exp_edge, input int exp_rises,
                          input int exp_hi);
      int   rises     = 0;
      int   done_cnt  = 0;
      int   done_edge = 0;
      int   hi        = 0;
      int   hi_max    = 0;
      int   early     = 0;
      int   addr_bad  = 0;
      logic prev_req  = 1'b0;
      logic [ADDR_W-1:0] held = '0;
      @(negedge pmu_clk);
      init_en = 1'b1;
      for (int n = 1; n <= 700; n++) begin
         @(posedge pmu_clk);
         #1;
         if (nvm.rd_req) begin
            if (!prev_req) begin
               chk({tag, "_addr"}, 32'(nvm.rd_addr), 32'(START + rises));
               rises++;
               held = nvm.rd_addr;
               hi   = 0;
            end else if (nvm.rd_addr !== held) begin
               addr_bad++;
            end
            hi++;
            if (hi > hi_max) hi_max = hi;
         end
         if (tag_status && !init_done && done_cnt == 0) early++;
         if (init_done) begin
            done_cnt++;
            if (done_cnt == 1) done_edge = n;
         end
         prev_req = nvm.rd_req;
         if (done_cnt > 0 && n == done_edge + 2) init_en = 1'b0;
         if (done_cnt > 0 && n == done_edge + 8) break;
      end
      init_en = 1'b0;
      chk({tag, "_done_edge"}, 32'(done_edge), 32'(exp_edge));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "_req_count"}, 32'(rises), 32'(exp_rises));
      chk({tag, "_req_hi_max"}, 32'(hi_max), 32'(exp_hi));
      chk({tag, "_addr_stable"}, 32'(addr_bad), 32'd0);
      chk({tag, "_tag_early"}, 32'(early), 32'd0);
   endtask

   task automatic chk_res(input string tag, input logic t, input logic [15:0] l,
                          input logic p, input logic e);
      chk({tag, "_tag_status"}, 32'(tag_status), 32'(t));
      chk({tag, "_lock_cfg"}, 32'(lock_cfg), 32'(l));
      chk({tag, "_kill_pwd_nz"}, 32'(kill_pwd_nz), 32'(p));
      chk({tag, "_init_err"}, 32'(init_err), 32'(e));
   endtask

   function automatic logic [31:0] outs_vec();
      return {5'd0, nvm.rd_req, nvm.rd_addr, init_done, tag_status, lock_cfg,
              kill_pwd_nz, init_err};
   endfunction

   initial begin
      bit found;
      set_mem(16'h0000, 16'h00A5, 16'h0000, 16'h0000);
      repeat (3) @(negedge pmu_clk);
      chk("reset_outs", outs_vec(), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge pmu_clk);
      chk("post_reset_outs", outs_vec(), 32'd0);

      dly = 0; no_ack_w = -1;
      set_mem(16'h0000, 16'h00A5, 16'h0000, 16'h0000);
      run_seq("norm", 13, 4, 1);
      chk_res("norm", 1'b0, 16'h00A5, 1'b0, 1'b0);

      set_mem(16'h0001, 16'hC3C3, 16'h1234, 16'h0000);
      run_seq("kill", 13, 4, 1);
      chk_res("kill", 1'b1, 16'hC3C3, 1'b1, 1'b0);

      dly = 5;
      set_mem(16'h0000, 16'h5A5A, 16'h0000, 16'h8000);
      run_seq("wait", 33, 4, 6);
      chk_res("wait", 1'b0, 16'h5A5A, 1'b1, 1'b0);

      dly = 0; no_ack_w = 2;
      set_mem(16'h0000, 16'h1111, 16'h0000, 16'h0000);
      run_seq("tmo", 263, 3, 255);
      chk("tmo_tag_status", 32'(tag_status), 32'd1);
      chk("tmo_lock_cfg", 32'(lock_cfg), 32'h0000FFFF);
      chk("tmo_init_err", 32'(init_err), 32'd1);

      // abort during the word-1 request, then re-init
      no_ack_w = -1;
      set_mem(16'h0000, 16'h0F0F, 16'h0000, 16'h0000);
      @(negedge pmu_clk);
      init_en = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
         @(posedge pmu_clk);
         #1;
         if (nvm.rd_req && nvm.rd_addr == ADDR_W'(1)) found = 1'b1;
      end
      chk("abort_reach_w1", 32'(found), 32'd1);
      init_en = 1'b0;
      @(posedge pmu_clk);
      #1;
      chk("abort_req_drop", 32'(nvm.rd_req), 32'd0);
      begin
         int pulses = 0;
         for (int n = 0; n < 10; n++) begin
            @(posedge pmu_clk);
            #1;
            if (init_done) pulses++;
         end
         chk("abort_no_done", 32'(pulses), 32'd0);
      end
      chk("abort_err_cleared", 32'(init_err), 32'd0);
      chk("abort_tag_cleared", 32'(tag_status), 32'd0);
      run_seq("rein", 13, 4, 1);
      chk_res("rein", 1'b0, 16'h0F0F, 1'b0, 1'b0);

      // async reset in the middle of a word-2 request
      dly = 3;
      @(negedge pmu_clk);
      init_en = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(posedge pmu_clk);
         #1;
         if (nvm.rd_req && nvm.rd_addr == ADDR_W'(2)) found = 1'b1;
      end
      chk("rst_reach_w2", 32'(found), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outs", outs_vec(), 32'd0);
      init_en = 1'b0;
      @(negedge pmu_clk);
      rst_n = 1'b1;
      repeat (3) @(negedge pmu_clk);
      chk("rst_release_idle", outs_vec(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
